// File: rtl/cbm2_keyboard.sv
// CBM-II keyboard matrix emulation: turns MiSTer ps2_key events into a 16x6 key
// matrix and returns the rows that the TPI 2 column selects address, active-low.
module cbm2_keyboard #(
   parameter logic [7:0] SHIFTLOCK_CODE = 8'h58,
   parameter logic [7:0] CLEAR_CODE     = 8'h07
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [7:0]  col_a_n,
   input  logic [7:0]  col_b_n,
   output logic [7:0]  row_n,
   output logic        shiftlock,
   output logic        key_strobe
);

   typedef struct packed {
      logic       valid;
      logic [3:0] col;
      logic [2:0] row;
   } kmap_t;

   logic              tog_q;
   logic              pend_q;
   logic              pend_pressed_q;
   logic              pend_ext_q;
   logic [7:0]        pend_code_q;
   logic [15:0][5:0]  matrix_q, matrix_d;
   logic              shiftlock_q, shiftlock_d;
   logic              strobe_q, strobe_d;
   logic [5:0]        row_q, row_d;
   logic              event_det;
   logic              is_clear, is_slock;
   kmap_t             kmap;
   logic [15:0][5:0]  eff;
   logic [15:0]       sel;
   logic [5:0]        rows_low;

   assign event_det = ps2_key[10] ^ tog_q;

   // Stage 1: detect the toggle edge and capture the event payload.
   always_ff @(posedge clk_sys) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         tog_q  <= ps2_key[10];
         pend_q <= 1'b0;
      end else begin
         tog_q  <= ps2_key[10];
         pend_q <= event_det;
      end
      // NOTE: the payload needs no reset; it is only consumed while pend_q is set.
      if (event_det) begin
         pend_pressed_q <= ps2_key[9];
         pend_ext_q     <= ps2_key[8];
         pend_code_q    <= ps2_key[7:0];
      end
   end

   always_comb begin
      kmap = '0;
      case ({pend_ext_q, pend_code_q})
         9'h005: kmap = {1'b1, 4'd0,  3'd0};
         9'h076: kmap = {1'b1, 4'd0,  3'd1};
         9'h00D: kmap = {1'b1, 4'd0,  3'd2};
         9'h014: kmap = {1'b1, 4'd0,  3'd4};
         9'h006: kmap = {1'b1, 4'd1,  3'd0};
         9'h016: kmap = {1'b1, 4'd1,  3'd2};
         9'h015: kmap = {1'b1, 4'd1,  3'd3};
         9'h01A: kmap = {1'b1, 4'd1,  3'd4};
         9'h004: kmap = {1'b1, 4'd2,  3'd0};
         9'h01C: kmap = {1'b1, 4'd2,  3'd1};
         9'h01E: kmap = {1'b1, 4'd2,  3'd2};
         9'h01D: kmap = {1'b1, 4'd2,  3'd3};
         9'h022: kmap = {1'b1, 4'd2,  3'd4};
         9'h00C: kmap = {1'b1, 4'd3,  3'd0};
         9'h01B: kmap = {1'b1, 4'd3,  3'd1};
         9'h026: kmap = {1'b1, 4'd3,  3'd2};
         9'h024: kmap = {1'b1, 4'd3,  3'd3};
         9'h021: kmap = {1'b1, 4'd3,  3'd4};
         9'h003: kmap = {1'b1, 4'd4,  3'd0};
         9'h023: kmap = {1'b1, 4'd4,  3'd1};
         9'h025: kmap = {1'b1, 4'd4,  3'd2};
         9'h02D: kmap = {1'b1, 4'd4,  3'd3};
         9'h02A: kmap = {1'b1, 4'd4,  3'd4};
         9'h00B: kmap = {1'b1, 4'd5,  3'd0};
         9'h02B: kmap = {1'b1, 4'd5,  3'd1};
         9'h02E: kmap = {1'b1, 4'd5,  3'd2};
         9'h02C: kmap = {1'b1, 4'd5,  3'd3};
         9'h032: kmap = {1'b1, 4'd5,  3'd4};
         9'h083: kmap = {1'b1, 4'd6,  3'd0};
         9'h034: kmap = {1'b1, 4'd6,  3'd1};
         9'h036: kmap = {1'b1, 4'd6,  3'd2};
         9'h035: kmap = {1'b1, 4'd6,  3'd3};
         9'h031: kmap = {1'b1, 4'd6,  3'd4};
         9'h029: kmap = {1'b1, 4'd6,  3'd5};
         9'h00A: kmap = {1'b1, 4'd7,  3'd0};
         9'h033: kmap = {1'b1, 4'd7,  3'd1};
         9'h03D: kmap = {1'b1, 4'd7,  3'd2};
         9'h03C: kmap = {1'b1, 4'd7,  3'd3};
         9'h03A: kmap = {1'b1, 4'd7,  3'd4};
         9'h001: kmap = {1'b1, 4'd8,  3'd0};
         9'h03B: kmap = {1'b1, 4'd8,  3'd1};
         9'h03E: kmap = {1'b1, 4'd8,  3'd2};
         9'h043: kmap = {1'b1, 4'd8,  3'd3};
         9'h041: kmap = {1'b1, 4'd8,  3'd4};
         9'h012: kmap = {1'b1, 4'd8,  3'd5};
         9'h059: kmap = {1'b1, 4'd8,  3'd5};
         9'h009: kmap = {1'b1, 4'd9,  3'd0};
         9'h042: kmap = {1'b1, 4'd9,  3'd1};
         9'h046: kmap = {1'b1, 4'd9,  3'd2};
         9'h044: kmap = {1'b1, 4'd9,  3'd3};
         9'h049: kmap = {1'b1, 4'd9,  3'd4};
         9'h078: kmap = {1'b1, 4'd10, 3'd0};
         9'h04B: kmap = {1'b1, 4'd10, 3'd1};
         9'h045: kmap = {1'b1, 4'd10, 3'd2};
         9'h05A: kmap = {1'b1, 4'd10, 3'd3};
         9'h04A: kmap = {1'b1, 4'd10, 3'd4};
         9'h04C: kmap = {1'b1, 4'd11, 3'd0};
         9'h04D: kmap = {1'b1, 4'd11, 3'd1};
         9'h04E: kmap = {1'b1, 4'd11, 3'd2};
         9'h054: kmap = {1'b1, 4'd11, 3'd3};
         9'h052: kmap = {1'b1, 4'd11, 3'd4};
         9'h066: kmap = {1'b1, 4'd12, 3'd0};
         9'h055: kmap = {1'b1, 4'd12, 3'd1};
         9'h05B: kmap = {1'b1, 4'd12, 3'd2};
         9'h05D: kmap = {1'b1, 4'd12, 3'd3};
         9'h16C: kmap = {1'b1, 4'd13, 3'd0};
         9'h171: kmap = {1'b1, 4'd13, 3'd1};
         9'h170: kmap = {1'b1, 4'd13, 3'd2};
         9'h172: kmap = {1'b1, 4'd14, 3'd0};
         9'h175: kmap = {1'b1, 4'd14, 3'd1};
         9'h16B: kmap = {1'b1, 4'd14, 3'd2};
         9'h174: kmap = {1'b1, 4'd14, 3'd3};
         9'h07C: kmap = {1'b1, 4'd15, 3'd0};
         9'h07B: kmap = {1'b1, 4'd15, 3'd1};
         9'h079: kmap = {1'b1, 4'd15, 3'd2};
         9'h15A: kmap = {1'b1, 4'd15, 3'd3};
         default: kmap = '0;
      endcase
   end

   assign is_clear = !pend_ext_q && (pend_code_q == CLEAR_CODE);
   assign is_slock = !pend_ext_q && (pend_code_q == SHIFTLOCK_CODE);

   // Stage 2: apply the looked-up event to the matrix or the special keys.
   always_comb begin
      // NOTE: defaults first so no path through this block leaves a latch behind.
      matrix_d    = matrix_q;
      shiftlock_d = shiftlock_q;
      strobe_d    = 1'b0;
      if (pend_q) begin
         if (is_clear) begin
            if (pend_pressed_q) begin
               matrix_d = '0;
               strobe_d = 1'b1;
            end
         end else if (is_slock) begin
            if (pend_pressed_q) begin
               shiftlock_d = ~shiftlock_q;
               strobe_d    = 1'b1;
            end
         end else if (kmap.valid && (kmap.row <= 3'd5)) begin
            matrix_d[kmap.col][kmap.row] = pend_pressed_q;
            strobe_d                     = 1'b1;
         end
      end
   end

   // Latched SHIFT LOCK holds the shift position down on top of the real matrix.
   always_comb begin
      eff       = matrix_q;
      eff[8][5] = matrix_q[8][5] | shiftlock_q;
      sel       = ~{col_b_n, col_a_n};
      rows_low  = '0;
      for (int c = 0; c < 16; c++) begin
         if (sel[c]) rows_low = rows_low | eff[c];
      end
      row_d = ~rows_low;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         matrix_q    <= '0;
         shiftlock_q <= 1'b0;
         strobe_q    <= 1'b0;
         row_q       <= 6'h3F;
      end else begin
         matrix_q    <= matrix_d;
         shiftlock_q <= shiftlock_d;
         strobe_q    <= strobe_d;
         row_q       <= row_d;
      end
   end

   assign row_n      = {2'b11, row_q};
   assign shiftlock  = shiftlock_q;
   assign key_strobe = strobe_q;

endmodule

// File: tb/tb_cbm2_keyboard.sv
// Scoreboard bench for cbm2_keyboard: a key-position model predicts each strobe's
// resulting SHIFT LOCK and matrix; a monitor checks them as the DUT strobes.
module tb_cbm2_keyboard;

   logic        clk_sys;
   logic        reset;
   logic [10:0] ps2_key;
   logic [7:0]  col_a_n;
   logic [7:0]  col_b_n;
   logic [7:0]  row_n;
   logic        shiftlock;
   logic        key_strobe;

   cbm2_keyboard dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .col_a_n    (col_a_n),
      .col_b_n    (col_b_n),
      .row_n      (row_n),
      .shiftlock  (shiftlock),
      .key_strobe (key_strobe)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   typedef struct {
      bit       ext;
      bit [7:0] code;
      int       col;
      int       row;
   } key_t;

   typedef struct packed {
      logic             slock;
      logic [15:0][5:0] m;
   } exp_t;

   key_t     keys[6];
   bit [5:0] m[16];
   bit       slock;
   exp_t     exp_q[$];
   int       n_cmp = 0;
   int       n_bad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [7:0] exp_row(exp_t e, logic [15:0] cols_n);
      logic [5:0] low;
      low = '0;
      for (int c = 0; c < 16; c++) begin
         if (!cols_n[c]) begin
            low = low | e.m[c];
            if (c == 8) low[5] = low[5] | e.slock;
         end
      end
      return {2'b11, ~low};
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      e.slock = slock;
      for (int c = 0; c < 16; c++) e.m[c] = m[c];
      return e;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 16; c++) m[c] = '0;
      slock = 1'b0;
   endtask

   task automatic model_apply(bit pressed, bit ext, bit [7:0] code);
      if (!ext && code == 8'h07) begin
         if (pressed) begin
            for (int c = 0; c < 16; c++) m[c] = '0;
            exp_q.push_back(snapshot());
         end
      end else if (!ext && code == 8'h58) begin
         if (pressed) begin
            slock = ~slock;
            exp_q.push_back(snapshot());
         end
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (keys[k].ext == ext && keys[k].code == code) begin
               m[keys[k].col][keys[k].row] = pressed;
               exp_q.push_back(snapshot());
               break;
            end
         end
      end
   endtask

   task automatic send(bit pressed, bit ext, bit [7:0] code);
      ps2_key = {~ps2_key[10], pressed, ext, code};
      model_apply(pressed, ext, code);
      tick(2);
   endtask

   task automatic check_row(logic [7:0] a, logic [7:0] b, logic [7:0] exp, string name);
      col_a_n = a;
      col_b_n = b;
      tick(2);
      check(name, row_n, exp);
   endtask

   // Monitor: each strobe pops one prediction; rows are checked one cycle later.
   initial begin
      exp_t        e;
      logic [15:0] snap_cols;
      forever begin
         @(negedge clk_sys);
         if (key_strobe === 1'b1) begin
            snap_cols = {col_b_n, col_a_n};
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("mon_shiftlock", shiftlock, e.slock);
               @(negedge clk_sys);
               check("mon_row_n", row_n, exp_row(e, snap_cols));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cols;
      int          idx;
      bit          pr;

      keys[0] = '{1'b0, 8'h1C, 2, 1};
      keys[1] = '{1'b0, 8'h12, 8, 5};
      keys[2] = '{1'b0, 8'h59, 8, 5};
      keys[3] = '{1'b0, 8'h5A, 10, 3};
      keys[4] = '{1'b1, 8'h75, 14, 1};
      keys[5] = '{1'b0, 8'h76, 0, 1};
      model_reset();

      // Reset with the toggle bit already high: no event must follow.
      reset   = 1'b1;
      ps2_key = 11'h400;
      col_a_n = 8'h00;
      col_b_n = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("reset_row_n", row_n, 8'hFF);
      check("reset_shiftlock", shiftlock, 1'b0);
      check("reset_strobe", key_strobe, 1'b0);
      tick(3);
      check("reset_no_spurious", key_strobe, 1'b0);

      // Single key press/release.
      send(1'b1, 1'b0, 8'h1C);
      check_row(8'hFB, 8'hFF, 8'hFD, "a_col2");
      check_row(8'hFE, 8'hFF, 8'hFF, "a_col0");
      send(1'b0, 1'b0, 8'h1C);
      check_row(8'hFB, 8'hFF, 8'hFF, "a_released");

      // Multiple selected columns, extended key, unmapped key.
      send(1'b1, 1'b0, 8'h1C);
      send(1'b1, 1'b0, 8'h5A);
      check_row(8'hFB, 8'hFB, 8'hF5, "a_return_or");
      send(1'b1, 1'b1, 8'h75);
      check_row(8'hFF, 8'hBF, 8'hFD, "crsr_up");
      send(1'b1, 1'b0, 8'h75);
      check_row(8'hFF, 8'hBF, 8'hFD, "kp8_unmapped");
      send(1'b0, 1'b0, 8'h1C);
      send(1'b0, 1'b0, 8'h5A);
      send(1'b0, 1'b1, 8'h75);
      check_row(8'h00, 8'h00, 8'hFF, "all_released");

      // SHIFT LOCK latch.
      send(1'b1, 1'b0, 8'h58);
      send(1'b0, 1'b0, 8'h58);
      check("slock_on", shiftlock, 1'b1);
      check_row(8'hFF, 8'hFE, 8'hDF, "slock_row5");
      send(1'b1, 1'b0, 8'h12);
      send(1'b0, 1'b0, 8'h12);
      check_row(8'hFF, 8'hFE, 8'hDF, "slock_after_lshift");
      send(1'b1, 1'b0, 8'h58);
      check_row(8'hFF, 8'hFE, 8'hFF, "slock_off_row");
      check("slock_off", shiftlock, 1'b0);
      send(1'b0, 1'b0, 8'h58);

      // CLEAR releases everything held.
      send(1'b1, 1'b0, 8'h1C);
      send(1'b1, 1'b0, 8'h76);
      check_row(8'h00, 8'h00, 8'hFD, "held_a_esc");
      send(1'b1, 1'b0, 8'h07);
      check_row(8'h00, 8'h00, 8'hFF, "clear_empty");
      check("clear_shiftlock", shiftlock, 1'b0);
      send(1'b0, 1'b0, 8'h07);

      // Reset one cycle after an event toggle drops the event and clears the matrix.
      send(1'b1, 1'b0, 8'h76);
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      model_reset();
      check("midreset_strobe", key_strobe, 1'b0);
      check_row(8'h00, 8'h00, 8'hFF, "midreset_empty");
      send(1'b1, 1'b0, 8'h1C);
      check_row(8'hFB, 8'hFF, 8'hFD, "after_reset_a");
      send(1'b0, 1'b0, 8'h1C);

      // Randomized events and column selects.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0:       cols = ~(16'h0001 << $urandom_range(0, 15));
            1:       cols = 16'($urandom);
            2:       cols = 16'h0000;
            default: cols = 16'hFFFF;
         endcase
         col_a_n = cols[7:0];
         col_b_n = cols[15:8];
         idx = int'($urandom_range(0, 9));
         pr  = 1'($urandom_range(0, 1));
         if (idx < 6)
            send(pr, keys[idx].ext, keys[idx].code);
         else if (idx == 6)
            send(pr, 1'b0, 8'h75);
         else if (idx == 7)
            send(pr, 1'b0, 8'h58);
         else if (idx == 8)
            send(pr && ($urandom_range(0, 2) == 0), 1'b0, 8'h07);
         else
            send(pr, keys[0].ext, keys[0].code);
         tick(int'($urandom_range(0, 2)));
      end

      tick(6);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
